pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Run-control and hazard unit for a 5-stage in-order pipeline without forwarding.
// Owns the HALTED/RUN/STEP/DRAIN FSM, the EX/MEM/WB writer scoreboard and the stall/flush counters.
module pipeline_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_rd_wr,
   input  logic             ex_branch_taken,
   output logic             fe_advance,
   output logic             be_advance,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             running,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {HALTED, RUN, STEP, DRAIN} state_t;

   state_t state, state_nxt;

   logic            vld_p0, vld_p1, vld_p2;
   logic [RA_W-1:0] rd_p0, rd_p1, rd_p2;

   logic wr_p0, wr_p1, wr_p2;
   logic hit_rs1, hit_rs2, hazard, sb_empty;
   logic stall_evt, flush_evt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Writes to x0 are architecturally discarded, so they never create a hazard.
   assign wr_p0 = vld_p0 & (rd_p0 != '0);
   assign wr_p1 = vld_p1 & (rd_p1 != '0);
   assign wr_p2 = vld_p2 & (rd_p2 != '0);

   assign hit_rs1 = id_use_rs1 & (id_rs1 != '0) &
                    ((wr_p0 & (rd_p0 == id_rs1)) |
                     (wr_p1 & (rd_p1 == id_rs1)) |
                     (wr_p2 & (rd_p2 == id_rs1)));
   assign hit_rs2 = id_use_rs2 & (id_rs2 != '0) &
                    ((wr_p0 & (rd_p0 == id_rs2)) |
                     (wr_p1 & (rd_p1 == id_rs2)) |
                     (wr_p2 & (rd_p2 == id_rs2)));
   assign hazard   = id_valid & (hit_rs1 | hit_rs2);
   assign sb_empty = ~(vld_p0 | vld_p1 | vld_p2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= HALTED;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fe_advance   = 1'b0;
      be_advance   = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      pc_load      = 1'b0;
      stall_evt    = 1'b0;
      flush_evt    = 1'b0;
      case (state)
         HALTED: begin
            if (halt_req)      state_nxt = HALTED;
            else if (run_req)  state_nxt = RUN;
            else if (step_req) state_nxt = STEP;
         end
         RUN, STEP: begin
            // A taken branch squashes the ID instruction, so any hazard it had is moot.
            if (ex_branch_taken) begin
               fe_advance   = 1'b1;
               be_advance   = 1'b1;
               id_ex_bubble = 1'b1;
               if_id_flush  = 1'b1;
               pc_load      = 1'b1;
               flush_evt    = 1'b1;
            end else if (hazard) begin
               be_advance   = 1'b1;
               id_ex_bubble = 1'b1;
               stall_evt    = 1'b1;
            end else begin
               fe_advance   = 1'b1;
               be_advance   = 1'b1;
            end
            if (halt_req) begin
               state_nxt = DRAIN;
            end else if (state == STEP && (ex_branch_taken || (id_valid && !hazard))) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            be_advance   = 1'b1;
            id_ex_bubble = 1'b1;
            if (ex_branch_taken) begin
               if_id_flush = 1'b1;
               pc_load     = 1'b1;
            end
            if (sb_empty) state_nxt = HALTED;
         end
         default: state_nxt = HALTED;
      endcase
   end

   assign pc_inc  = fe_advance & ~pc_load;
   assign running = (state == RUN) || (state == STEP);

   // Scoreboard stage boundary: ID/EX -> EX/MEM -> MEM/WB
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (be_advance) begin
         vld_p0 <= id_valid & id_rd_wr & ~id_ex_bubble;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (be_advance) begin
         rd_p0 <= id_rd;
         rd_p1 <= rd_p0;
         rd_p2 <= rd_p1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
         if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, RAW stalls, x0, branch vs hazard, single-step,
// counter saturation and reset during DRAIN.
module tb_pipeline_ctrl;
   localparam int RA_W  = 5;
   localparam int CNT_W = 8;

   localparam logic [6:0] C_OFF   = 7'b0000000;
   localparam logic [6:0] C_RUN   = 7'b1100101;
   localparam logic [6:0] C_STALL = 7'b0110001;
   localparam logic [6:0] C_BR    = 7'b1111011;
   localparam logic [6:0] C_DRAIN = 7'b0110000;
   localparam logic [6:0] C_DRBR  = 7'b0111010;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic run_req, halt_req, step_req;
   logic id_valid, id_use_rs1, id_use_rs2, id_rd_wr, ex_branch_taken;
   logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
   logic fe_advance, be_advance, id_ex_bubble, if_id_flush, pc_inc, pc_load, running;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0] ctl;

   int tests = 0;
   int fails = 0;

   pipeline_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_rd_wr(id_rd_wr), .ex_branch_taken(ex_branch_taken),
      .fe_advance(fe_advance), .be_advance(be_advance), .id_ex_bubble(id_ex_bubble),
      .if_id_flush(if_id_flush), .pc_inc(pc_inc), .pc_load(pc_load), .running(running),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign ctl = {fe_advance, be_advance, id_ex_bubble, if_id_flush, pc_inc, pc_load, running};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [RA_W-1:0] rs1, input logic u1,
                         input logic [RA_W-1:0] rs2, input logic u2,
                         input logic [RA_W-1:0] rd, input logic wr);
      id_valid   = v;
      id_rs1     = rs1;
      id_use_rs1 = u1;
      id_rs2     = rs2;
      id_use_rs2 = u2;
      id_rd      = rd;
      id_rd_wr   = wr;
   endtask

   task automatic idle();
      run_req = 1'b0;
      halt_req = 1'b0;
      step_req = 1'b0;
      ex_branch_taken = 1'b0;
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic test_reset();
      run_req = 1'b1;
      ex_branch_taken = 1'b1;
      set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1);
      tick(); tick();
      tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_OFF); end
      tests++; if (stall_cnt !== 8'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
      tests++; if (flush_cnt !== 8'd0) begin fails++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
      idle();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL halted_idle cyc%0d: got %b expected %b", i, ctl, C_OFF); end
      end
   endtask

   task automatic test_run_independent();
      tick();
      run_req = 1'b1;
      #1;
      tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL run_req_cycle: got %b expected %b", ctl, C_OFF); end
      for (int i = 0; i < 6; i++) begin
         tick();
         run_req = 1'b0;
         set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, RA_W'(10 + i), 1'b1);
         #1;
         tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL indep_ctl cyc%0d: got %b expected %b", i, ctl, C_RUN); end
      end
      tick();
      idle();
      #1;
      tests++; if (stall_cnt !== 8'd0) begin fails++; $display("FAIL indep_stall_cnt: got %0d expected 0", stall_cnt); end
      tick(); tick(); tick();
   endtask

   task automatic test_raw_stall();
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL raw_writer: got %b expected %b", ctl, C_RUN); end
      for (int i = 0; i < 3; i++) begin
         tick();
         set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
         #1;
         tests++; if (ctl !== C_STALL) begin fails++; $display("FAIL raw_stall cyc%0d: got %b expected %b", i, ctl, C_STALL); end
      end
      tick();
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL raw_issue: got %b expected %b", ctl, C_RUN); end
      tests++; if (stall_cnt !== 8'd3) begin fails++; $display("FAIL raw_stall_cnt: got %0d expected 3", stall_cnt); end
      tick();
      idle();
   endtask

   task automatic test_x0_and_operands();
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL x0_writer: got %b expected %b", ctl, C_RUN); end
      tick();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL x0_reader: got %b expected %b", ctl, C_RUN); end
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL x7_writer: got %b expected %b", ctl, C_RUN); end
      tick();
      set_id(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL rs1_unused: got %b expected %b", ctl, C_RUN); end
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
      #1;
      tests++; if (ctl !== C_STALL) begin fails++; $display("FAIL rs2_hazard: got %b expected %b", ctl, C_STALL); end
      tick();
      idle();
      #1;
      tests++; if (stall_cnt !== 8'd4) begin fails++; $display("FAIL x0_stall_cnt: got %0d expected 4", stall_cnt); end
      tick(); tick();
   endtask

   task automatic test_branch_hazard();
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL br_writer: got %b expected %b", ctl, C_RUN); end
      tick();
      set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      ex_branch_taken = 1'b1;
      #1;
      tests++; if (ctl !== C_BR) begin fails++; $display("FAIL br_over_hazard: got %b expected %b", ctl, C_BR); end
      tick();
      idle();
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL br_after: got %b expected %b", ctl, C_RUN); end
      tests++; if (flush_cnt !== 8'd1) begin fails++; $display("FAIL br_flush_cnt: got %0d expected 1", flush_cnt); end
      tests++; if (stall_cnt !== 8'd4) begin fails++; $display("FAIL br_stall_cnt: got %0d expected 4", stall_cnt); end
      tick(); tick(); tick();
   endtask

   task automatic test_step();
      tick();
      halt_req = 1'b1;
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL halt_req_cycle: got %b expected %b", ctl, C_RUN); end
      tick();
      halt_req = 1'b0;
      #1;
      tests++; if (ctl !== C_DRAIN) begin fails++; $display("FAIL halt_drain: got %b expected %b", ctl, C_DRAIN); end
      tick();
      #1;
      tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL halt_done: got %b expected %b", ctl, C_OFF); end
      tick();
      ex_branch_taken = 1'b1;
      #1;
      tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL halted_branch: got %b expected %b", ctl, C_OFF); end
      tests++; if (flush_cnt !== 8'd1) begin fails++; $display("FAIL halted_flush_cnt: got %0d expected 1", flush_cnt); end
      tick();
      ex_branch_taken = 1'b0;
      step_req = 1'b1;
      #1;
      tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL step_req_cycle: got %b expected %b", ctl, C_OFF); end
      tick();
      step_req = 1'b0;
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL step_issue: got %b expected %b", ctl, C_RUN); end
      tick();
      set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      tests++; if (ctl !== C_DRAIN) begin fails++; $display("FAIL step_drain1: got %b expected %b", ctl, C_DRAIN); end
      tick();
      ex_branch_taken = 1'b1;
      #1;
      tests++; if (ctl !== C_DRBR) begin fails++; $display("FAIL drain_branch: got %b expected %b", ctl, C_DRBR); end
      tick();
      ex_branch_taken = 1'b0;
      #1;
      tests++; if (ctl !== C_DRAIN) begin fails++; $display("FAIL step_drain3: got %b expected %b", ctl, C_DRAIN); end
      tick();
      #1;
      tests++; if (ctl !== C_DRAIN) begin fails++; $display("FAIL step_drain4: got %b expected %b", ctl, C_DRAIN); end
      tick();
      #1;
      tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL step_halted: got %b expected %b", ctl, C_OFF); end
      tests++; if (stall_cnt !== 8'd4) begin fails++; $display("FAIL step_stall_cnt: got %0d expected 4", stall_cnt); end
      idle();
   endtask

   task automatic test_saturation();
      tick();
      run_req = 1'b1;
      #1;
      tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL sat_run_req: got %b expected %b", ctl, C_OFF); end
      tick();
      run_req = 1'b0;
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL sat_first: got %b expected %b", ctl, C_RUN); end
      repeat (400) tick();
      tests++; if (stall_cnt !== 8'hFF) begin fails++; $display("FAIL sat_reach: got %0h expected ff", stall_cnt); end
      repeat (4) tick();
      tests++; if (stall_cnt !== 8'hFF) begin fails++; $display("FAIL sat_hold: got %0h expected ff", stall_cnt); end
   endtask

   task automatic test_reset_in_drain();
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      #1;
      tests++; if (ctl !== C_DRAIN) begin fails++; $display("FAIL pre_reset_drain: got %b expected %b", ctl, C_DRAIN); end
      #2;
      rst = 1'b0;
      #1;
      tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL reset_mid_drain: got %b expected %b", ctl, C_OFF); end
      tests++; if (stall_cnt !== 8'd0) begin fails++; $display("FAIL reset_mid_stall_cnt: got %0h expected 0", stall_cnt); end
      tests++; if (flush_cnt !== 8'd0) begin fails++; $display("FAIL reset_mid_flush_cnt: got %0h expected 0", flush_cnt); end
      #2;
      rst = 1'b1;
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (ctl !== C_OFF) begin fails++; $display("FAIL post_reset_halted cyc%0d: got %b expected %b", i, ctl, C_OFF); end
      end
      tick();
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL post_reset_no_hazard: got %b expected %b", ctl, C_RUN); end
      tick();
      idle();
      #1;
      tests++; if (stall_cnt !== 8'd0) begin fails++; $display("FAIL post_reset_stall_cnt: got %0d expected 0", stall_cnt); end
   endtask

   initial begin
      idle();
      test_reset();
      test_run_independent();
      test_raw_stall();
      test_x0_and_operands();
      test_branch_hazard();
      test_step();
      test_saturation();
      test_reset_in_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
